// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the ALU. Runs one load or
// store per request on a ready-based data bus and reports faults.
//
// Ports:
//   clk, rst (sync, active-high), clk_enable (pipeline advance/freeze)
//   req_valid, req_is_store, req_funct3, addr, store_data : request in
//   mem_addr, mem_read, mem_write, mem_wstrb, mem_wdata   : bus request
//   mem_rdata, mem_ready                                  : bus response
//   busy, done, load_data, fault                          : to writeback
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] F_OK      = 2'b00;
    localparam logic [1:0] F_MISALGN = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;
    localparam logic [1:0] F_ILLEGAL = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  lo_q, lo_d;
    logic        st_q, st_d;

    logic [31:0] mem_addr_d;
    logic        mem_read_d;
    logic        mem_write_d;
    logic [3:0]  mem_wstrb_d;
    logic [31:0] mem_wdata_d;
    logic        done_d;
    logic [31:0] load_data_d;
    logic [1:0]  fault_d;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  strb_req;
    logic [31:0] wdata_req;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    assign busy = (state_q != IDLE);

    // Width legality on the live request; stores have no BU/HU form.
    assign illegal = (req_funct3[1:0] == 2'b11)
                  || (req_funct3 == 3'b110)
                  || (req_is_store && req_funct3[2]);

    assign misaligned = (req_funct3[1:0] == 2'b01 && addr[0])
                     || (req_funct3 == 3'b010 && addr[1:0] != 2'b00);

    always_comb begin
        strb_req  = 4'b1111;
        wdata_req = store_data;
        case (req_funct3[1:0])
            2'b00: begin
                strb_req  = 4'b0001 << addr[1:0];
                wdata_req = {4{store_data[7:0]}};
            end
            2'b01: begin
                strb_req  = 4'b0011 << addr[1:0];
                wdata_req = {2{store_data[15:0]}};
            end
            default: begin
                strb_req  = 4'b1111;
                wdata_req = store_data;
            end
        endcase
    end

    // Lane select uses the registered low address bits of the access.
    assign rbyte = mem_rdata[{lo_q, 3'b000} +: 8];
    assign rhalf = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = mem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{rbyte[7]}}, rbyte};
            3'b001:  load_ext = {{16{rhalf[15]}}, rhalf};
            3'b100:  load_ext = {24'd0, rbyte};
            3'b101:  load_ext = {16'd0, rhalf};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        st_d        = st_q;
        mem_addr_d  = mem_addr;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        mem_wstrb_d = mem_wstrb;
        mem_wdata_d = mem_wdata;
        done_d      = 1'b0;
        load_data_d = load_data;
        fault_d     = fault;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    f3_d  = req_funct3;
                    lo_d  = addr[1:0];
                    st_d  = req_is_store;
                    cnt_d = 16'd0;
                    if (illegal) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        fault_d     = F_ILLEGAL;
                        load_data_d = 32'd0;
                    end else if (misaligned) begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        fault_d     = F_MISALGN;
                        load_data_d = 32'd0;
                    end else begin
                        state_d     = REQ;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_read_d  = !req_is_store;
                        mem_write_d = req_is_store;
                        mem_wstrb_d = req_is_store ? strb_req : 4'b0000;
                        mem_wdata_d = wdata_req;
                    end
                end
            end
            REQ: begin
                // A ready in the final allowed cycle still completes.
                if (mem_ready) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    fault_d     = F_OK;
                    load_data_d = st_q ? 32'd0 : load_ext;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                end else if (cnt_q == LAST) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    fault_d     = F_TIMEOUT;
                    load_data_d = 32'd0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            f3_q      <= 3'd0;
            lo_q      <= 2'd0;
            st_q      <= 1'b0;
            mem_addr  <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            done      <= 1'b0;
            load_data <= 32'd0;
            fault     <= 2'd0;
        end else if (clk_enable) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            st_q      <= st_d;
            mem_addr  <= mem_addr_d;
            mem_read  <= mem_read_d;
            mem_write <= mem_write_d;
            mem_wstrb <= mem_wstrb_d;
            mem_wdata <= mem_wdata_d;
            done      <= done_d;
            load_data <= load_data_d;
            fault     <= fault_d;
        end
    end

endmodule
